afifo_wr_ctrl: RTL

- Write-domain half of the asynchronous FIFO. Runs on CLK_O1 from the clock/reset generator, with its reset derived from that generator.
- Accepts write requests and produces the RAM write address and write enable.
- Publishes a Gray-coded write pointer to the read domain.
- Synchronises the read domain's Gray pointer in order to compute FULL, ALMOST_FULL and a fill level.
- A sticky overflow flag records every write attempted while FULL.

---
 rtl/afifo_pkg.sv | 29 ++
 rtl/afifo_wr_ctrl_if.sv | 28 ++
 rtl/afifo_sync.sv | 30 +++
 rtl/afifo_wr_ctrl.sv | 92 +++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared definitions for both halves of the asynchronous FIFO.
// Holds the default address width and the Gray/binary conversion helpers.
// The read-domain controller imports this same package.
package afifo_pkg;

  // Default RAM address width. The FIFO depth is 2**ADDR_W_DEF.
  localparam int ADDR_W_DEF = 4;

  // Working width of the conversion helpers. Callers zero-extend their
  // pointer to this width and truncate the result. The extra zero MSBs
  // leave the low bits of either conversion unchanged.
  localparam int PTR_MAX_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1'b1);
  endfunction

  // Reflected Gray code to binary (prefix XOR from the MSB down).
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/afifo_wr_ctrl_if.sv
// Write-side bus of the asynchronous FIFO.
// master : the writer and read-domain environment driving WE / RPTR_G.
// slave  : the write controller.
interface afifo_wr_ctrl_if
  import afifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              WE;
  logic [ADDR_W:0]   RPTR_G;
  logic              WACK;
  logic [ADDR_W-1:0] WADDR;
  logic [ADDR_W:0]   WPTR_G;
  logic              FULL;
  logic              ALMOST_FULL;
  logic [ADDR_W:0]   WLEVEL;
  logic              OVF;

  modport master (
    output WE, RPTR_G,
    input  WACK, WADDR, WPTR_G, FULL, ALMOST_FULL, WLEVEL, OVF
  );

  modport slave (
    input  WE, RPTR_G,
    output WACK, WADDR, WPTR_G, FULL, ALMOST_FULL, WLEVEL, OVF
  );
endinterface

// File: rtl/afifo_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Only one bit of the pointer changes per step. A bus-wide chain of flops is
// therefore safe here. The read domain reuses this chain for WPTR_G.
module afifo_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] stage_r [SYNC_STAGES];

  // Shift the asynchronous input through the flop chain, clearing it on reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[SYNC_STAGES-1];
endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-domain controller of the asynchronous FIFO.
// - Accepts writes and drives the RAM address and write enable.
// - Publishes a Gray write pointer to the read domain.
// - Derives FULL, ALMOST_FULL and a fill level from the synchronised read pointer.
// - Latches a sticky overflow flag for any write attempted while FULL.
module afifo_wr_ctrl
  import afifo_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = 12
) (
  input  logic           CLK,
  input  logic           RST,
  afifo_wr_ctrl_if.slave bus
);
  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0]  wbin_r;
  logic [PTR_W-1:0]  wptr_g_r;
  logic [PTR_W-1:0]  wlevel_r;
  logic [ADDR_W-1:0] waddr_r;
  logic              full_r;
  logic              afull_r;
  logic              ovf_r;

  logic              wack_s;
  logic [PTR_W-1:0]  wbin_next_s;
  logic [PTR_W-1:0]  wgray_next_s;
  logic [PTR_W-1:0]  rq_s;
  logic [PTR_W-1:0]  rbin_s;
  logic [PTR_W-1:0]  full_cmp_s;
  logic [PTR_W-1:0]  level_s;
  logic              full_next_s;
  logic              afull_next_s;

  afifo_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (PTR_W)
  ) u_rptr_sync (
    .CLK  (CLK),
    .RST  (RST),
    .din  (bus.RPTR_G),
    .dout (rq_s)
  );

  // Next-state pointer arithmetic and flag evaluation. FULL and the level
  // use the post-write pointer. A write that fills the FIFO therefore
  // raises FULL on its own edge.
  always_comb begin
    wack_s       = bus.WE & ~full_r;
    wbin_next_s  = wbin_r + PTR_W'(wack_s);
    wgray_next_s = PTR_W'(bin2gray(PTR_MAX_W'(wbin_next_s)));
    rbin_s       = PTR_W'(gray2bin(PTR_MAX_W'(rq_s)));
    // Full when the write pointer is one lap ahead: the top two Gray bits
    // are inverted and the rest match.
    full_cmp_s   = {~rq_s[ADDR_W:ADDR_W-1], rq_s[ADDR_W-2:0]};
    full_next_s  = (wgray_next_s == full_cmp_s);
    level_s      = wbin_next_s - rbin_s;
    afull_next_s = (level_s >= PTR_W'(AFULL_TH));
  end

  // Register the pointers and status flags. A write dropped while FULL
  // leaves the pointers unchanged, because wack_s gates the increment.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wbin_r   <= '0;
      wptr_g_r <= '0;
      waddr_r  <= '0;
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
      wlevel_r <= '0;
      ovf_r    <= 1'b0;
    end else begin
      wbin_r   <= wbin_next_s;
      wptr_g_r <= wgray_next_s;
      waddr_r  <= wbin_next_s[ADDR_W-1:0];
      full_r   <= full_next_s;
      afull_r  <= afull_next_s;
      wlevel_r <= level_s;
      ovf_r    <= ovf_r | (bus.WE & full_r);
    end
  end

  assign bus.WACK        = wack_s;
  assign bus.WADDR       = waddr_r;
  assign bus.WPTR_G      = wptr_g_r;
  assign bus.FULL        = full_r;
  assign bus.ALMOST_FULL = afull_r;
  assign bus.WLEVEL      = wlevel_r;
  assign bus.OVF         = ovf_r;
endmodule
